// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - per-frame go/done sequencer for three draw clients with a shared pixel port
// Ports:
//   clk, resetn             : system clock, asynchronous active-low reset
//   enable                  : game running; gates the frame timer
//   client_en[2:0]          : per-client enable mask (0 top paddle, 1 bottom paddle, 2 ball)
//   clr_err                 : clears the sticky timeout_err / overrun flags
//   done[2:0]               : client completion levels
//   x_in, y_in, color_in,
//   we_in                   : packed client pixel buses {c2,c1,c0}
//   go[2:0]                 : registered one-hot start request to the active client
//   vga_x/y/color/plot      : registered pixel-write port, fed only by the active client
//   busy, frame_done        : not-idle status, one-cycle end-of-frame pulse
//   timeout_err[2:0], overrun : sticky error flags
module draw_sequencer #(
  parameter int FRAME_CYCLES = 50000000,
  parameter int TIMEOUT      = 12000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [2:0]  client_en,
  input  logic        clr_err,
  input  logic [2:0]  done,
  input  logic [23:0] x_in,
  input  logic [20:0] y_in,
  input  logic [8:0]  color_in,
  input  logic [2:0]  we_in,
  output logic [2:0]  go,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_color,
  output logic        vga_plot,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  timeout_err,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [25:0] FRAME_LAST   = 26'(FRAME_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [25:0] frame_cnt;
  logic [23:0] to_cnt, to_cnt_nxt;
  logic        pending;
  logic [2:0]  done_prev;
  logic [2:0]  go_nxt, err_set;
  logic        tick, start, complete, timed_out;
  logic        has_first, has_next;
  logic [1:0]  first_idx, next_idx;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_c;
  logic        sel_we;

  assign tick       = enable && (frame_cnt == FRAME_LAST);
  assign start      = enable && (tick || pending);
  // A client left in its done state counts only after it drops and rises again.
  assign complete   = done[idx] && !done_prev[idx];
  assign timed_out  = (to_cnt == TIMEOUT_LAST);
  assign busy       = (state != IDLE);
  assign frame_done = (state == FINISH);

  // Lowest enabled client overall, and lowest enabled client above idx.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    has_first = 1'b0;
    first_idx = 2'd0;
    has_next  = 1'b0;
    next_idx  = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (client_en[i]) begin
        has_first = 1'b1;
        first_idx = 2'(i);
      end
      if (client_en[i] && (i > int'(idx))) begin
        has_next = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  always_comb begin
    sel_x  = x_in[7:0];
    sel_y  = y_in[6:0];
    sel_c  = color_in[2:0];
    sel_we = we_in[0];
    case (idx)
      2'd1: begin
        sel_x  = x_in[15:8];
        sel_y  = y_in[13:7];
        sel_c  = color_in[5:3];
        sel_we = we_in[1];
      end
      2'd2: begin
        sel_x  = x_in[23:16];
        sel_y  = y_in[20:14];
        sel_c  = color_in[8:6];
        sel_we = we_in[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    go_nxt     = 3'b000;
    to_cnt_nxt = 24'd0;
    err_set    = 3'b000;
    case (state)
      IDLE: begin
        if (start) begin
          if (has_first) begin
            state_nxt = RUN;
            idx_nxt   = first_idx;
            go_nxt    = 3'b001 << first_idx;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      RUN: begin
        if (complete || timed_out) begin
          // Completion wins over a simultaneous timeout.
          if (!complete) err_set = 3'b001 << idx;
          if (has_next) begin
            idx_nxt = next_idx;
            go_nxt  = 3'b001 << next_idx;
          end else begin
            state_nxt = FINISH;
          end
        end else begin
          go_nxt     = 3'b001 << idx;
          to_cnt_nxt = to_cnt + 24'd1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      idx         <= 2'd0;
      go          <= 3'b000;
      to_cnt      <= 24'd0;
      frame_cnt   <= 26'd0;
      pending     <= 1'b0;
      done_prev   <= 3'b111;
      overrun     <= 1'b0;
      timeout_err <= 3'b000;
      vga_x       <= 8'd0;
      vga_y       <= 7'd0;
      vga_color   <= 3'd0;
      vga_plot    <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      go        <= go_nxt;
      to_cnt    <= to_cnt_nxt;
      done_prev <= done;

      if (!enable || tick) frame_cnt <= 26'd0;
      else                 frame_cnt <= frame_cnt + 26'd1;

      // A tick during a frame is remembered and starts the next frame from IDLE.
      if (!enable)                    pending <= 1'b0;
      else if (tick && busy)          pending <= 1'b1;
      else if (!busy && start)        pending <= 1'b0;

      if (tick && busy)  overrun <= 1'b1;
      else if (clr_err)  overrun <= 1'b0;

      timeout_err <= (clr_err ? 3'b000 : timeout_err) | err_set;

      if (state == RUN) begin
        vga_x     <= sel_x;
        vga_y     <= sel_y;
        vga_color <= sel_c;
        vga_plot  <= sel_we;
      end else begin
        vga_x     <= 8'd0;
        vga_y     <= 7'd0;
        vga_color <= 3'd0;
        vga_plot  <= 1'b0;
      end
    end
  end

endmodule
